ipv4_dst_extract: RTL

Ingress header-parse stage that feeds the route-lookup TCAM. It consumes a 32-bit word stream of IPv4 packets, validates the header, captures the destination address, and issues exactly one lookup request per accepted packet over a valid/ready handshake. It also drains the payload, drops malformed packets, and counts the drops.

---
 rtl/ipv4_dst_extract_pkg.sv | 25 ++
 rtl/ipv4_csum_acc.sv | 31 +++
 rtl/ipv4_dst_extract.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ipv4_dst_extract_pkg.sv
// Shared encodings and IPv4 header field positions for the destination-extract stage.
package ohr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DROP  = 3'd4
  } state_t;

  localparam logic [3:0] IHL_MIN  = 4'd5;
  localparam logic [3:0] IPV4_VER = 4'd4;

  localparam logic [3:0] TTL_WORD = 4'd2;
  localparam logic [3:0] DST_WORD = 4'd4;

  localparam int TTL_HI = 31;
  localparam int TTL_LO = 24;
  localparam int IHL_HI = 27;
  localparam int IHL_LO = 24;
  localparam int VER_HI = 31;
  localparam int VER_LO = 28;

endpackage

// File: rtl/ipv4_csum_acc.sv
// Ones'-complement accumulator over 16-bit halves of 32-bit header words.
// sum is the folded total including the word presented this cycle.
module ipv4_csum_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        acc_en,
  input  logic [31:0] data,
  output logic [15:0] sum
);

  logic [19:0] acc;
  logic [19:0] base;
  logic [19:0] nxt;
  logic [16:0] fold1;

  // Partial end-around fold on every add keeps the 20-bit accumulator from overflowing at IHL=15.
  assign base  = clr ? 20'd0 : ({4'd0, acc[15:0]} + {16'd0, acc[19:16]});
  assign nxt   = base + {4'd0, data[31:16]} + {4'd0, data[15:0]};
  assign fold1 = {1'b0, nxt[15:0]} + {13'd0, nxt[19:16]};
  assign sum   = fold1[15:0] + {15'd0, fold1[16]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= nxt;
    end
  end

endmodule

// File: rtl/ipv4_dst_extract.sv
// IPv4 header parse: validates each packet and issues one destination lookup per accepted packet.
// Define HDR_CHECKSUM_EN to also drop packets whose header checksum does not verify.
module ipv4_dst_extract
  import ohr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IF_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [IF_W-1:0]  in_if,
  output logic             in_ready,
  output logic [WIDTH-1:0] lkp_addr,
  output logic [IF_W-1:0]  lkp_src_if,
  output logic             lkp_ttl_exp,
  output logic             lkp_valid,
  input  logic             lkp_ready,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t     state;
  logic [3:0] ihl_q;
  logic [3:0] idx;
  logic       eop_seen;
  logic [1:0] drop_inc;
  logic       beat;
  logic       sop_bad;
  logic       last_hdr;
  logic       csum_ok;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign in_ready = (state != ISSUE);
  assign beat     = in_valid && in_ready;
  assign sop_bad  = (in_data[VER_HI:VER_LO] != IPV4_VER) || (in_data[IHL_HI:IHL_LO] < IHL_MIN);
  assign last_hdr = (idx == (ihl_q - 4'd1));

`ifdef HDR_CHECKSUM_EN
  logic [15:0] csum_sum;

  ipv4_csum_acc u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (in_sop),
    .acc_en (beat && (in_sop || (state == HDR))),
    .data   (in_data),
    .sum    (csum_sum)
  );

  assign csum_ok = (csum_sum == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  // A SOP interrupting HDR costs the old packet plus possibly the new one, hence up to two per cycle.
  // A packet already in DROP was counted on entry, so its truncation by SOP is not counted again.
  always_comb begin
    drop_inc = 2'd0;
    if (beat) begin
      if (in_sop) begin
        if (state == HDR) drop_inc = drop_inc + 2'd1;
        if (sop_bad || in_eop) drop_inc = drop_inc + 2'd1;
      end else if (state == HDR) begin
        if (last_hdr ? !csum_ok : in_eop) drop_inc = 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ihl_q       <= '0;
      idx         <= '0;
      eop_seen    <= 1'b0;
      lkp_valid   <= 1'b0;
      lkp_addr    <= '0;
      lkp_src_if  <= '0;
      lkp_ttl_exp <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      drop_cnt <= sat_add(drop_cnt, drop_inc);
      if (state == ISSUE) begin
        if (lkp_ready) begin
          lkp_valid <= 1'b0;
          state     <= eop_seen ? IDLE : DRAIN;
        end
      end else if (beat) begin
        if (in_sop) begin
          ihl_q      <= in_data[IHL_HI:IHL_LO];
          idx        <= 4'd1;
          lkp_src_if <= in_if;
          state      <= in_eop ? IDLE : (sop_bad ? DROP : HDR);
        end else begin
          case (state)
            HDR: begin
              idx <= idx + 4'd1;
              if (idx == TTL_WORD) lkp_ttl_exp <= (in_data[TTL_HI:TTL_LO] <= 8'd1);
              if (idx == DST_WORD) lkp_addr <= in_data;
              if (last_hdr) begin
                eop_seen <= in_eop;
                if (csum_ok) begin
                  state     <= ISSUE;
                  lkp_valid <= 1'b1;
                end else begin
                  state <= in_eop ? IDLE : DROP;
                end
              end else if (in_eop) begin
                state <= IDLE;
              end
            end
            DRAIN, DROP: if (in_eop) state <= IDLE;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
